// File: rtl/branch_resolve_unit.sv
// Branch resolution: decodes control transfers, checks the front-end prediction,
// issues a held redirect with a one-cycle flush and pulses BTB updates.
// Optional performance counters are enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] op1,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic            lt_flag,
    input  logic            ltu_flag,
    input  logic            zero_flag,
    input  logic            predicted_taken,
    input  logic [XLEN-1:0] predicted_target,
    output logic            in_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush,
`ifdef BRU_PERF_CNT_EN
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
`endif
    output logic            btb_update_valid,
    output logic [XLEN-1:0] btb_update_pc,
    output logic [XLEN-1:0] btb_update_target,
    output logic            btb_update_taken
);

    typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t          state_r, state_next_s;
    logic            is_jal_s, is_jalr_s, is_branch_s, is_ctrl_s;
    logic            br_cond_s, actual_taken_s, mispredict_s;
    logic            accept_s, btb_fire_s;
    logic [XLEN-1:0] sum_s, target_s, fallthrough_s;
    logic            flush_r, btb_valid_r, btb_taken_r;
    logic [XLEN-1:0] redirect_pc_r, btb_pc_r, btb_target_r;

    assign is_jal_s    = (opcode == 7'b1101111);
    assign is_jalr_s   = (opcode == 7'b1100111);
    assign is_branch_s = (opcode == 7'b1100011);
    assign is_ctrl_s   = is_jal_s | is_jalr_s | is_branch_s;

    // Branch condition selected by func3
    always_comb begin
        br_cond_s = 1'b0;
        case (func3)
            3'b000:  br_cond_s = zero_flag;
            3'b001:  br_cond_s = ~zero_flag;
            3'b100:  br_cond_s = lt_flag;
            3'b101:  br_cond_s = ~lt_flag;
            3'b110:  br_cond_s = ltu_flag;
            3'b111:  br_cond_s = ~ltu_flag;
            default: br_cond_s = 1'b0;
        endcase
    end

    assign actual_taken_s = is_jal_s | is_jalr_s | (is_branch_s & br_cond_s);
    assign sum_s          = (is_jalr_s ? op1 : pc) + immediate;
    assign target_s       = is_jalr_s ? {sum_s[XLEN-1:1], 1'b0} : sum_s;
    assign fallthrough_s  = pc + XLEN'(4);
    assign mispredict_s   = (actual_taken_s != predicted_taken) ||
                            (actual_taken_s && predicted_taken && (target_s != predicted_target));

    assign in_ready   = ~redirect_valid;
    assign accept_s   = in_valid & in_ready;
    // Non-control instructions predicted taken still update the BTB to clear the false hit
    assign btb_fire_s = accept_s & (is_ctrl_s | predicted_taken);

    // Next-state logic for the redirect handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && mispredict_s) begin
                    state_next_s = PEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PEND: begin
                if (redirect_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = PEND;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, redirect, flush and BTB update registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            flush_r       <= 1'b0;
            redirect_pc_r <= '0;
            btb_valid_r   <= 1'b0;
            btb_pc_r      <= '0;
            btb_target_r  <= '0;
            btb_taken_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            flush_r     <= accept_s & mispredict_s;
            btb_valid_r <= btb_fire_s;
            if (accept_s && mispredict_s) begin
                redirect_pc_r <= actual_taken_s ? target_s : fallthrough_s;
            end
            if (btb_fire_s) begin
                btb_pc_r     <= pc;
                btb_target_r <= target_s;
                btb_taken_r  <= actual_taken_s;
            end
        end
    end

    assign redirect_valid    = (state_r == PEND);
    assign redirect_pc       = redirect_pc_r;
    assign flush             = flush_r;
    assign btb_update_valid  = btb_valid_r;
    assign btb_update_pc     = btb_pc_r;
    assign btb_update_target = btb_target_r;
    assign btb_update_taken  = btb_taken_r;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] branch_cnt_r, mispredict_cnt_r;

    // Wrapping performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_r     <= '0;
            mispredict_cnt_r <= '0;
        end else begin
            if (accept_s && is_ctrl_s) begin
                branch_cnt_r <= branch_cnt_r + CNT_W'(1);
            end
            if (accept_s && mispredict_s) begin
                mispredict_cnt_r <= mispredict_cnt_r + CNT_W'(1);
            end
        end
    end

    assign branch_count     = branch_cnt_r;
    assign mispredict_count = mispredict_cnt_r;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scoreboard bench for branch_resolve_unit; expectations are pushed at
// issue time and popped one cycle after acceptance.
module tb_branch_resolve_unit;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, in_valid, lt_flag, ltu_flag, zero_flag, predicted_taken;
    logic [XLEN-1:0] pc, immediate, op1, predicted_target;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic            in_ready, redirect_valid, redirect_ready, flush;
    logic [XLEN-1:0] redirect_pc, btb_update_pc, btb_update_target;
    logic            btb_update_valid, btb_update_taken;
`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] branch_count, mispredict_count;
`endif

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc(pc), .immediate(immediate),
        .op1(op1), .opcode(opcode), .func3(func3), .lt_flag(lt_flag), .ltu_flag(ltu_flag),
        .zero_flag(zero_flag), .predicted_taken(predicted_taken),
        .predicted_target(predicted_target), .in_ready(in_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush(flush),
`ifdef BRU_PERF_CNT_EN
        .branch_count(branch_count), .mispredict_count(mispredict_count),
`endif
        .btb_update_valid(btb_update_valid), .btb_update_pc(btb_update_pc),
        .btb_update_target(btb_update_target), .btb_update_taken(btb_update_taken)
    );

    typedef struct packed {
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
        logic        bv;
        logic [31:0] bpc;
        logic [31:0] btgt;
        logic        ct;
        logic        bt;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] p,
                         input logic [31:0] im, input logic [31:0] o1, input logic l,
                         input logic lu, input logic z, input logic pt, input logic [31:0] ptg,
                         input logic erv, input logic [31:0] erpc, input logic ebv,
                         input logic [31:0] ebtgt, input logic ect, input logic ebt);
        exp_t e;
        chk("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
        opcode = op; func3 = f3; pc = p; immediate = im; op1 = o1;
        lt_flag = l; ltu_flag = lu; zero_flag = z;
        predicted_taken = pt; predicted_target = ptg; in_valid = 1'b1;
        e.rv = erv; e.rpc = erpc; e.fl = erv; e.bv = ebv; e.bpc = p;
        e.btgt = ebtgt; e.ct = ect; e.bt = ebt;
        sb_q.push_back(e);
    endtask

    task automatic step_pop();
        exp_t e;
        @(posedge clk); #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
            chk("flush", {31'd0, flush}, {31'd0, e.fl});
            chk("btb_update_valid", {31'd0, btb_update_valid}, {31'd0, e.bv});
            if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
            if (e.bv) begin
                chk("btb_update_pc", btb_update_pc, e.bpc);
                chk("btb_update_taken", {31'd0, btb_update_taken}, {31'd0, e.bt});
                if (e.ct) chk("btb_update_target", btb_update_target, e.btgt);
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; redirect_ready = 1'b1;
        opcode = OP_ADD; func3 = 3'd0; pc = '0; immediate = '0; op1 = '0;
        lt_flag = 1'b0; ltu_flag = 1'b0; zero_flag = 1'b0;
        predicted_taken = 1'b0; predicted_target = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_btb_valid", {31'd0, btb_update_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_btb_pc", btb_update_pc, 32'd0);
        chk("rst_btb_target", btb_update_target, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Correct predictions back to back: BEQ, BLT, BGEU not taken, func3 010, JAL
        issue(OP_BR, 3'b000, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h120,
              1'b0, 32'h0, 1'b1, 32'h120, 1'b1, 1'b1);
        step_pop();
        issue(OP_BR, 3'b100, 32'h104, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h144,
              1'b0, 32'h0, 1'b1, 32'h144, 1'b1, 1'b1);
        step_pop();
        issue(OP_BR, 3'b111, 32'h108, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,
              1'b0, 32'h0, 1'b1, 32'h118, 1'b1, 1'b0);
        step_pop();
        issue(OP_BR, 3'b010, 32'h110, 32'h20, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,
              1'b0, 32'h0, 1'b1, 32'h130, 1'b1, 1'b0);
        step_pop();
        issue(OP_JAL, 3'b000, 32'h10C, 32'h7F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8FC,
              1'b0, 32'h0, 1'b1, 32'h8FC, 1'b1, 1'b1);
        step_pop();
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_btb_valid", {31'd0, btb_update_valid}, 32'd0);
        chk("idle_btb_pc_held", btb_update_pc, 32'h10C);
        chk("idle_redirect_valid", {31'd0, redirect_valid}, 32'd0);

        // BNE not taken but predicted taken, redirect accepted immediately
        issue(OP_BR, 3'b001, 32'h200, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h240,
              1'b1, 32'h204, 1'b1, 32'h240, 1'b1, 1'b0);
        step_pop();
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bne_rv_drop", {31'd0, redirect_valid}, 32'd0);
        chk("bne_flush_drop", {31'd0, flush}, 32'd0);
        chk("bne_btb_drop", {31'd0, btb_update_valid}, 32'd0);

        // JALR target mismatch with fetch stalling the redirect for three cycles
        redirect_ready = 1'b0;
        issue(OP_JALR, 3'b000, 32'h400, 32'h10, 32'h1001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000,
              1'b1, 32'h1010, 1'b1, 32'h1010, 1'b1, 1'b1);
        step_pop();
        chk("jalr_in_ready_c1", {31'd0, in_ready}, 32'd0);
        opcode = OP_ADD; pc = 32'h480; predicted_taken = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("jalr_hold_rv", {31'd0, redirect_valid}, 32'd1);
            chk("jalr_hold_pc", redirect_pc, 32'h1010);
            chk("jalr_hold_flush", {31'd0, flush}, 32'd0);
            chk("jalr_hold_no_btb", {31'd0, btb_update_valid}, 32'd0);
            chk("jalr_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; redirect_ready = 1'b1;
        @(posedge clk); #1;
        chk("jalr_release_rv", {31'd0, redirect_valid}, 32'd0);
        chk("jalr_release_ready", {31'd0, in_ready}, 32'd1);
        chk("jalr_release_flush", {31'd0, flush}, 32'd0);

        // Non-control predicted taken, non-control not predicted, pc wrap
        issue(OP_ADD, 3'b000, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h999,
              1'b1, 32'h304, 1'b1, 32'h0, 1'b0, 1'b0);
        step_pop();
        wait_ready();
        issue(OP_ADD, 3'b000, 32'h310, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
              1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step_pop();
        issue(OP_BR, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4,
              1'b1, 32'h0, 1'b1, 32'h4, 1'b1, 1'b0);
        step_pop();
        in_valid = 1'b0;
        wait_ready();

        // Reset in the second PEND cycle, then reset against a would-be mispredict
        redirect_ready = 1'b0;
        issue(OP_JAL, 3'b000, 32'h500, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
              1'b1, 32'h600, 1'b1, 32'h600, 1'b1, 1'b1);
        step_pop();
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pend2_rv", {31'd0, redirect_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstpend_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rstpend_ready", {31'd0, in_ready}, 32'd1);
        chk("rstpend_flush", {31'd0, flush}, 32'd0);
        chk("rstpend_rpc", redirect_pc, 32'd0);
        opcode = OP_BR; func3 = 3'b001; pc = 32'h700; zero_flag = 1'b1;
        predicted_taken = 1'b1; in_valid = 1'b1; redirect_ready = 1'b1;
        @(posedge clk); #1;
        chk("rstacc_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rstacc_flush", {31'd0, flush}, 32'd0);
        chk("rstacc_btb", {31'd0, btb_update_valid}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rv", {31'd0, redirect_valid}, 32'd0);

`ifdef BRU_PERF_CNT_EN
        chk("cnt_rst_branch", {28'd0, branch_count}, 32'd0);
        chk("cnt_rst_misp", {28'd0, mispredict_count}, 32'd0);
        issue(OP_BR, 3'b001, 32'h800, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h840,
              1'b1, 32'h804, 1'b1, 32'h840, 1'b1, 1'b0);
        step_pop();
        in_valid = 1'b0;
        wait_ready();
        for (int i = 0; i < 15; i++) begin
            issue(OP_BR, 3'b000, 32'h900 + 32'(i * 4), 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1,
                  32'h920 + 32'(i * 4), 1'b0, 32'h0, 1'b1, 32'h920 + 32'(i * 4), 1'b1, 1'b1);
            step_pop();
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("cnt_branch_wrap", {28'd0, branch_count}, 32'd0);
        chk("cnt_mispredict", {28'd0, mispredict_count}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath/address width; CNT_W, default 32, performance counter width.
REQ-002 SHALL have ports, one clock, reset synchronous active-high: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have inputs: in_valid 1 (instruction present); pc, immediate, op1 XLEN; opcode 7; func3 3; lt_flag, ltu_flag, zero_flag 1 (ALU compare flags); predicted_taken 1; predicted_target XLEN.
REQ-004 SHALL have output in_ready 1, meaning the block accepts an instruction this cycle.
REQ-005 SHALL have redirect outputs: redirect_valid 1, redirect_pc XLEN; and input redirect_ready 1 (fetch accepts redirect).
REQ-006 SHALL have output flush 1, a one-cycle pulse that kills younger in-flight instructions.
REQ-007 SHALL have BTB update outputs: btb_update_valid 1, btb_update_pc XLEN, btb_update_target XLEN, btb_update_taken 1.

Function
REQ-008 SHALL accept an instruction when in_valid && in_ready; in_ready = ~redirect_valid.
REQ-009 SHALL decode opcode 1101111 as JAL, 1100111 as JALR, and 1100011 as BRANCH; all other opcodes are non-control.
REQ-010 SHALL resolve a branch as taken per func3: 000 zero; 001 ~zero; 100 lt; 101 ~lt; 110 ltu; 111 ~ltu; 010/011 never taken. JAL/JALR are always taken.
REQ-011 SHALL compute target = pc+immediate (op1+immediate for JALR, bit 0 cleared), modulo 2^XLEN; fallthrough = pc+4, modulo 2^XLEN.
REQ-012 SHALL flag a mispredict when actual_taken != predicted_taken, or when both are taken and target != predicted_target.
REQ-013 SHALL treat a non-control instruction as actual_taken=0, so predicted_taken=1 on it is a mispredict.
REQ-014 SHALL, for every mispredict, register redirect_pc = target if actual_taken else fallthrough, and assert redirect_valid exactly one cycle after acceptance.
REQ-015 SHALL hold redirect_valid high with redirect_pc stable until a cycle where redirect_ready=1; redirect_valid deasserts the following cycle.
REQ-016 SHALL have two states, IDLE and PEND: IDLE->PEND on an accepted mispredict; PEND->IDLE on redirect_ready; PEND accepts no input.
REQ-017 SHALL assert flush only in the first cycle of redirect_valid, including when redirect_ready is already high that cycle.
REQ-018 SHALL pulse btb_update_valid for one cycle, one cycle after accepting a control instruction, with pc, target and actual_taken.
REQ-019 SHALL pulse btb_update_valid with btb_update_taken=0 for a non-control instruction predicted taken (BTB false-hit clear); it SHALL NOT pulse for other non-control instructions.
REQ-020 SHALL accept back-to-back correctly predicted instructions every cycle with no bubbles.
REQ-021 SHALL leave state and outputs unchanged when in_valid=0, except for the one-cycle pulses returning to 0.

Reset
REQ-022 SHALL, on rst at a clock edge, set the state to IDLE and drive redirect_valid, flush and btb_update_valid to 0, and redirect_pc and all btb_update_* data to 0.
REQ-023 SHALL discard any pending redirect when rst asserts mid-PEND, with no flush produced; rst takes priority over simultaneous acceptance.

Configuration
REQ-024 SHALL, with macro BRU_PERF_CNT_EN defined, add outputs branch_count and mispredict_count, each CNT_W bits, reset to 0.
REQ-025 SHALL increment branch_count per accepted control instruction and mispredict_count per mispredict, both wrapping to 0 past all-ones.
REQ-026 SHALL omit these ports and their logic entirely when BRU_PERF_CNT_EN is undefined; all other behaviour is identical.

Verification
REQ-027 SHALL cover: BEQ pc=0x100, imm=0x20, zero=1, predicted_taken=1, predicted_target=0x120 -> no redirect; next cycle btb_update_valid=1, target=0x120, taken=1.
REQ-028 SHALL cover: BNE pc=0x200, zero=1, predicted_taken=1 -> next cycle redirect_valid=1, redirect_pc=0x204, flush=1 for one cycle.
REQ-029 SHALL cover: JALR op1=0x1001, imm=0x10, predicted_target=0x1000 -> redirect_pc=0x1010; with redirect_ready=0 for 3 cycles, redirect held stable, in_ready=0, flush only in the first cycle.
REQ-030 SHALL cover: ADD opcode 0110011 at pc=0x300, predicted_taken=1 -> redirect_pc=0x304, btb_update_taken=0; pc=0xFFFFFFFC not taken -> fallthrough wraps to 0x0.
REQ-031 SHALL cover: rst asserted in the second PEND cycle -> redirect_valid=0 next cycle, in_ready=1, no flush.
REQ-032 SHALL cover, with BRU_PERF_CNT_EN and CNT_W=4: 16 branches, 1 of them mispredicted -> branch_count=0, mispredict_count=1.
